// File: rtl/ccc_reconfig_ctrl.sv
// APB sequencer that reprograms one CCC/PLL from a local register table,
// optionally verifies it, then releases the PLL reset and supervises LOCK.
module ccc_reconfig_ctrl #(
  parameter int         NUM_REGS     = 8,
  parameter logic [5:0] BASE_ADDR    = 6'h00,
  parameter int         RST_CYCLES   = 16,
  parameter int         BUSY_TIMEOUT = 255,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter bit         VERIFY       = 1'b1
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       tbl_we,
  input  logic [5:0] tbl_addr,
  input  logic [7:0] tbl_wdata,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic       locked,
  output logic       lock_lost,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  input  logic       LOCK,
  output logic       PLL_ARST_N
);

  localparam int MAX_A   = (RST_CYCLES > BUSY_TIMEOUT) ? RST_CYCLES : BUSY_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [5:0]    LAST_IDX   = 6'(NUM_REGS - 1);
  localparam logic [6:0]    NUM_REGS_W = 7'(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, PLL_RST, WSETUP, WACCESS, WWAIT,
    RSETUP, RACCESS, RWAIT, RELEASE, WAIT_LOCK, FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    err, err_nxt;
  logic          lock_meta, lock_sync, locked_prev;
  logic [7:0]    tbl [64];
  logic [7:0]    tbl_data;

  assign tbl_data  = tbl[idx];
  assign err_code  = err;
  assign locked    = lock_sync & PLL_ARST_N;
  assign lock_lost = locked_prev & ~locked & (state == IDLE);

  // The table survives reset; writes are blocked while a sequence owns it.
  always_ff @(posedge PCLK) begin
    if (tbl_we && !busy && !(state == IDLE && start) &&
        ({1'b0, tbl_addr} < NUM_REGS_W))
      tbl[tbl_addr] <= tbl_wdata;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      err         <= '0;
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      locked_prev <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      err         <= err_nxt;
      lock_meta   <= LOCK;
      lock_sync   <= lock_meta;
      locked_prev <= locked;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt   = '0;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = PLL_RST;
        end
      end
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WSETUP;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      WSETUP:  state_nxt = WACCESS;
      WACCESS: begin
        cnt_nxt   = '0;
        state_nxt = WWAIT;
      end
      WWAIT: begin
        if (!BUSY) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = VERIFY ? RSETUP : RELEASE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = WSETUP;
          end
        end else if (cnt == BUSY_LAST) begin
          if (err == 2'd0) err_nxt = 2'd1;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RSETUP:  state_nxt = RACCESS;
      RACCESS: begin
        if (PRDATA != tbl_data && err == 2'd0) err_nxt = 2'd2;
        cnt_nxt   = '0;
        state_nxt = RWAIT;
      end
      RWAIT: begin
        if (!BUSY) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = RELEASE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = RSETUP;
          end
        end else if (cnt == BUSY_LAST) begin
          if (err == 2'd0) err_nxt = 2'd1;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // The release cycle itself counts as the first cycle of the lock wait.
      RELEASE: begin
        cnt_nxt   = CW'(1);
        state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked) begin
          state_nxt = FINISH;
        end else if (cnt >= LOCK_LAST) begin
          if (err == 2'd0) err_nxt = 2'd3;
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    PLL_ARST_N = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE:                  busy = 1'b0;
      PLL_RST, WWAIT, RWAIT: PLL_ARST_N = 1'b0;
      WSETUP, WACCESS: begin
        PSEL       = 1'b1;
        PENABLE    = (state == WACCESS);
        PWRITE     = 1'b1;
        PADDR      = BASE_ADDR + idx;
        PWDATA     = tbl_data;
        PLL_ARST_N = 1'b0;
      end
      RSETUP, RACCESS: begin
        PSEL       = 1'b1;
        PENABLE    = (state == RACCESS);
        PADDR      = BASE_ADDR + idx;
        PLL_ARST_N = 1'b0;
      end
      FINISH: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Bench for ccc_reconfig_ctrl: a reactive CCC model plus scenario-level
// expectations for transactions, error codes and sequence timing.
module tb_ccc_reconfig_ctrl;

  localparam int         NUM_REGS     = 8;
  localparam logic [5:0] BASE         = 6'h00;
  localparam int         RST_CYCLES   = 16;
  localparam int         BUSY_TIMEOUT = 255;
  localparam int         LOCK_TIMEOUT = 65535;

  logic       PCLK = 1'b0;
  logic       PRESET_N;
  logic       tbl_we;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_wdata;
  logic       start;
  logic       busy, done, locked, lock_lost;
  logic [1:0] err_code;
  logic       PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       BUSY, LOCK, PLL_ARST_N;

  always #5 PCLK = ~PCLK;

  ccc_reconfig_ctrl #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .RST_CYCLES(RST_CYCLES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT), .VERIFY(1'b1)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .start(start), .busy(busy), .done(done),
    .err_code(err_code), .locked(locked), .lock_lost(lock_lost),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK),
    .PLL_ARST_N(PLL_ARST_N)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] tblModel [NUM_REGS];
  logic [7:0] cccMem [64];
  int         cfgDelay [2*NUM_REGS];
  int         cfgHang, cfgBadIdx, cfgLockDelay, cfgRstAt;
  logic [7:0] cfgBadVal;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic loadTable(input bit directed);
    for (int i = 0; i < NUM_REGS; i++) begin
      tblModel[i] = directed ? 8'((i + 1) * 8'h11) : 8'($urandom);
      @(negedge PCLK);
      tbl_we = 1'b1; tbl_addr = 6'(i); tbl_wdata = tblModel[i];
    end
    @(negedge PCLK);
    tbl_addr = 6'(NUM_REGS); tbl_wdata = 8'hA5;
    @(negedge PCLK);
    tbl_we = 1'b0;
  endtask

  task automatic clearCfg();
    for (int k = 0; k < 2*NUM_REGS; k++) cfgDelay[k] = 0;
    cfgHang = -1; cfgBadIdx = -1; cfgBadVal = 8'h00; cfgLockDelay = 20; cfgRstAt = -1;
  endtask

  // One reconfiguration run; the loop plays the CCC side each cycle.
  task automatic applyStimulus(input string name);
    int cyc, arstFall, relCyc, doneCyc, nAcc, nWr, nRd, lastAcc, lastAccD, busyLeft;
    int busyBad, protoBad, pitchBad, trBad, lostCnt, expWr, expRd, expErr, limit, extra;
    bit seenLow, seenRise, gotDone, rstHit;
    logic [1:0] doneErr;
    logic doneLocked;
    int setupCyc[$];
    logic setupW[$];
    logic [5:0] setupA[$];
    logic [7:0] setupD[$];

    arstFall = 0; relCyc = 0; doneCyc = 0; nAcc = 0; nWr = 0; nRd = 0; lastAcc = 0;
    lastAccD = 0; busyLeft = 0; busyBad = 0; protoBad = 0; pitchBad = 0; trBad = 0;
    lostCnt = 0; seenLow = 0; seenRise = 0; gotDone = 0; rstHit = 0;
    doneErr = 2'd0; doneLocked = 1'b0;

    if (cfgHang >= 0) begin expWr = cfgHang + 1; expRd = 0; end
    else begin expWr = NUM_REGS; expRd = NUM_REGS; end
    if (cfgHang >= 0) expErr = 1;
    else if (cfgBadIdx >= 0 && cfgBadVal != tblModel[cfgBadIdx]) expErr = 2;
    else if (cfgLockDelay < 0) expErr = 3;
    else expErr = 0;
    limit = (cfgLockDelay < 0) ? 70000 : 3000;

    @(negedge PCLK);
    cyc = 0;
    start = 1'b1; LOCK = 1'b0; BUSY = 1'b0;
    tbl_we = 1'b1; tbl_addr = 6'd0; tbl_wdata = ~tblModel[0];

    while (!gotDone && !rstHit && cyc < limit) begin
      @(negedge PCLK);
      cyc++;
      start     = (cyc == 5);
      tbl_we    = (cyc == 3);
      tbl_addr  = 6'(NUM_REGS - 1);
      tbl_wdata = ~tblModel[NUM_REGS-1];

      if (!PLL_ARST_N && !seenLow) begin seenLow = 1; arstFall = cyc; end
      if (PLL_ARST_N && seenLow && !seenRise) begin seenRise = 1; relCyc = cyc; end
      if (lock_lost) lostCnt++;
      if (done) begin
        gotDone = 1; doneCyc = cyc; doneErr = err_code; doneLocked = locked;
        if (busy) busyBad++;
      end else if (!busy) busyBad++;

      if (PSEL && !PENABLE) begin
        if (setupCyc.size() > 0 && nAcc > 0 &&
            (cyc - setupCyc[setupCyc.size()-1]) != 3 + cfgDelay[nAcc-1]) pitchBad++;
        setupCyc.push_back(cyc); setupW.push_back(PWRITE);
        setupA.push_back(PADDR); setupD.push_back(PWDATA);
      end

      if (PSEL && PENABLE) begin
        if (setupCyc.size() == 0 || setupCyc[setupCyc.size()-1] != cyc - 1 ||
            setupA[setupA.size()-1] != PADDR || setupW[setupW.size()-1] != PWRITE ||
            (PWRITE && setupD[setupD.size()-1] != PWDATA)) protoBad++;
        lastAcc = cyc;
        if (PWRITE) begin
          cccMem[PADDR] = PWDATA;
          nWr++;
          if (nWr == cfgRstAt) begin PRESET_N = 1'b0; rstHit = 1; end
        end else begin
          PRDATA = (nRd == cfgBadIdx) ? cfgBadVal : cccMem[PADDR];
          nRd++;
        end
        busyLeft = (nAcc == cfgHang) ? 1000000 : cfgDelay[nAcc];
        lastAccD = busyLeft;
        nAcc++;
      end else begin
        BUSY = (busyLeft > 0);
        if (busyLeft > 0) busyLeft--;
      end

      if (seenRise && cfgLockDelay >= 0 && cyc == relCyc + cfgLockDelay) LOCK = 1'b1;
    end
    start = 1'b0; tbl_we = 1'b0; BUSY = 1'b0;

    if (rstHit) begin
      @(negedge PCLK);
      checkOutput({name, "/rst_psel"}, PSEL, 0);
      checkOutput({name, "/rst_penable"}, PENABLE, 0);
      checkOutput({name, "/rst_arst_n"}, PLL_ARST_N, 1);
      checkOutput({name, "/rst_busy"}, busy, 0);
      PRESET_N = 1'b1;
      return;
    end

    checkOutput({name, "/done_seen"}, gotDone, 1);
    if (!gotDone) return;
    checkOutput({name, "/arst_fall"}, arstFall, 1);
    checkOutput({name, "/arst_len"}, setupCyc.size() > 0 ? setupCyc[0] - arstFall : -1, RST_CYCLES);
    checkOutput({name, "/n_writes"}, nWr, expWr);
    checkOutput({name, "/n_reads"}, nRd, expRd);
    for (int k = 0; k < setupCyc.size(); k++) begin
      if (k < expWr + expRd) begin
        bit expW;
        int e;
        expW = (k < expWr);
        e = expW ? k : k - expWr;
        if (setupW[k] != expW || setupA[k] != 6'(BASE + 6'(e)) ||
            (expW && setupD[k] != tblModel[e])) trBad++;
      end
    end
    checkOutput({name, "/transactions"}, trBad, 0);
    checkOutput({name, "/apb_protocol"}, protoBad, 0);
    checkOutput({name, "/apb_pitch"}, pitchBad, 0);
    checkOutput({name, "/release_time"}, relCyc - lastAcc,
                (cfgHang >= 0) ? 1 + BUSY_TIMEOUT : 2 + lastAccD);
    checkOutput({name, "/done_time"}, doneCyc - relCyc,
                (cfgLockDelay >= 0) ? cfgLockDelay + 3 : LOCK_TIMEOUT);
    checkOutput({name, "/err_code"}, doneErr, expErr);
    checkOutput({name, "/locked_at_done"}, doneLocked, (cfgLockDelay >= 0) ? 1 : 0);
    checkOutput({name, "/busy_window"}, busyBad, 0);
    checkOutput({name, "/no_lock_lost"}, lostCnt, 0);

    extra = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (PSEL || busy || done) extra++;
    end
    checkOutput({name, "/no_restart"}, extra, 0);
    checkOutput({name, "/err_hold"}, err_code, expErr);
  endtask

  initial begin
    int firstLost, lostCnt;
    PRESET_N = 1'b0; start = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    PRDATA = '0; BUSY = 1'b0; LOCK = 1'b1;
    for (int a = 0; a < 64; a++) cccMem[a] = 8'h00;

    repeat (4) @(negedge PCLK);
    checkOutput("reset/psel", PSEL, 0);
    checkOutput("reset/penable", PENABLE, 0);
    checkOutput("reset/pwrite", PWRITE, 0);
    checkOutput("reset/paddr", PADDR, 0);
    checkOutput("reset/pwdata", PWDATA, 0);
    checkOutput("reset/arst_n", PLL_ARST_N, 1);
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/done", done, 0);
    checkOutput("reset/err", err_code, 0);
    checkOutput("reset/lock_lost", lock_lost, 0);
    checkOutput("reset/locked", locked, 0);
    PRESET_N = 1'b1; LOCK = 1'b0;

    loadTable(1'b1);
    clearCfg();
    applyStimulus("basic");

    // Loss of lock while idle must produce exactly one pulse.
    @(negedge PCLK);
    checkOutput("lost/locked_before", locked, 1);
    LOCK = 1'b0; lostCnt = 0; firstLost = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge PCLK);
      if (lock_lost) begin
        lostCnt++;
        if (firstLost < 0) firstLost = k;
      end
      if (k == 10) LOCK = 1'b1;
    end
    checkOutput("lost/pulses", lostCnt, 1);
    checkOutput("lost/delay_2to3", (firstLost >= 2 && firstLost <= 3), 1);
    checkOutput("lost/locked_after", locked, 1);

    clearCfg(); cfgHang = 2;
    applyStimulus("busy_timeout");

    clearCfg(); cfgBadIdx = 5; cfgBadVal = 8'h00;
    applyStimulus("verify_err");

    clearCfg(); cfgLockDelay = -1;
    applyStimulus("lock_timeout");

    clearCfg(); cfgRstAt = 4;
    applyStimulus("reset_mid");
    clearCfg();
    applyStimulus("after_reset");

    for (int r = 0; r < 6; r++) begin
      loadTable(1'b0);
      clearCfg();
      for (int k = 0; k < 2*NUM_REGS; k++) cfgDelay[k] = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        cfgBadIdx = int'($urandom_range(0, NUM_REGS - 1));
        cfgBadVal = ~tblModel[cfgBadIdx];
      end
      cfgLockDelay = int'($urandom_range(0, 30));
      applyStimulus("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccc_reconfig_ctrl.md
Name: ccc_reconfig_ctrl

Overview:
APB sequencer for dynamic reconfiguration of one fabric CCC/PLL instance through its 6-bit-address, 8-bit-data configuration port. On request it performs a fixed sequence: hold the PLL in reset, write a locally stored register table, optionally read it back, release the reset and wait for LOCK. After that it monitors LOCK continuously and flags any loss. It sits between system-level control logic and the CCC configuration pins, and is the only master on that port.

Parameters:
NUM_REGS, 8, number of table entries written per sequence (1..64)
BASE_ADDR, 6'h00, PADDR of table entry 0; entry i goes to BASE_ADDR+i (6-bit wrap)
RST_CYCLES, 16, PCLK cycles PLL_ARST_N is held low before the first write
BUSY_TIMEOUT, 255, maximum cycles spent waiting for BUSY to fall after an access
LOCK_TIMEOUT, 65535, maximum cycles spent waiting for synchronised LOCK after release
VERIFY, 1, 1 = read back and compare every entry after all writes

Ports:
PCLK  in  1  single clock for the whole block and the CCC APB port
PRESET_N  in  1  synchronous active-low reset
tbl_we  in  1  table write strobe (ignored while busy=1)
tbl_addr  in  6  table index (values >= NUM_REGS are ignored)
tbl_wdata  in  8  table data
start  in  1  request reconfiguration; accepted only in IDLE
busy  out  1  high from the cycle after start is accepted until the cycle done pulses
done  out  1  one-cycle pulse at the end of a sequence
err_code  out  2  0 ok, 1 busy timeout, 2 verify mismatch, 3 lock timeout; valid when done=1, held until the next start
locked  out  1  synchronised LOCK, gated low while the PLL is in reset
lock_lost  out  1  one-cycle pulse when locked falls outside a sequence
PSEL  out  1  APB select to CCC
PENABLE  out  1  APB enable to CCC
PWRITE  out  1  APB direction to CCC
PADDR  out  6  APB address to CCC
PWDATA  out  8  APB write data to CCC
PRDATA  in  8  APB read data from CCC
BUSY  in  1  CCC configuration busy (PCLK domain)
LOCK  in  1  CCC lock (asynchronous; 2-flop synchroniser inside)
PLL_ARST_N  out  1  PLL reset to CCC, active low

Behaviour:
- Reset values: all APB outputs 0, PLL_ARST_N=1, busy=0, done=0, err_code=0, lock_lost=0, locked=0, synchroniser flops 0. The table is not cleared by reset.
- FSM states: IDLE, PLL_RST, WSETUP, WACCESS, WWAIT, RSETUP, RACCESS, RWAIT, RELEASE, WAIT_LOCK, FINISH.
- IDLE: if start=1, clear err_code, load idx=0 and the counter, go to PLL_RST.
- PLL_RST: PLL_ARST_N=0 for exactly RST_CYCLES cycles, then go to WSETUP.
- WSETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+idx, PWDATA=table[idx]. Next cycle is WACCESS (PENABLE=1, same address and data). Next cycle is WWAIT with PSEL=PENABLE=0.
- WWAIT: when BUSY=0, increment idx. If idx was the last entry, go to RSETUP (VERIFY=1, idx reset to 0) or RELEASE; otherwise go to WSETUP. If BUSY stays 1 for BUSY_TIMEOUT cycles, set err_code=1 and go to RELEASE.
- Read path mirrors the write path with PWRITE=0. PRDATA is sampled in the RACCESS cycle. On a mismatch, record err_code=2 (first error only) and continue through the remaining entries.
- One APB access therefore takes a minimum of 3 cycles. Back-to-back writes with BUSY=0 issue a new PSEL every 3 cycles.
- RELEASE: set PLL_ARST_N=1, load the LOCK_TIMEOUT counter, go to WAIT_LOCK. PLL_ARST_N is always released, including after an error.
- WAIT_LOCK: on locked=1, go to FINISH. On timeout, set err_code=3 (only if no earlier error) and go to FINISH.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- locked = LOCK synchronised through 2 flops AND PLL_ARST_N.
- lock_lost pulses on a 1->0 transition of locked only while the FSM is in IDLE.
- start while busy=1 is ignored. A tbl_we in the same cycle as an accepted start is ignored.
- PRESET_N low at any point: next cycle the FSM is in IDLE, APB idle, PLL_ARST_N=1. Any partially written configuration is left in the CCC as written.
- Counters are sized by $clog2 of their parameter; idx wraps within 6 bits.

Test Plan:
- Load table 0x11..0x88, start with BUSY=0 and LOCK rising 20 cycles after release -> PLL_ARST_N low for 16 cycles; 8 writes to addr 0x00..0x07 at a 3-cycle pitch; 8 reads; done with err_code=0; locked=1.
- Hold BUSY=1 after the 3rd write -> after 255 cycles PLL_ARST_N=1, done pulses, err_code=1, no further PSEL.
- Return PRDATA=0x00 on entry 5 readback -> all 8 reads still issued; done with err_code=2.
- LOCK held 0 -> done exactly 65535 cycles after RELEASE with err_code=3, locked=0.
- Completed sequence, then drop LOCK for 10 cycles -> one lock_lost pulse 2-3 cycles later; start pulsed during busy is ignored, with no second sequence.
- Assert PRESET_N=0 during the 4th write access -> next cycle PSEL=0, PENABLE=0, PLL_ARST_N=1, busy=0; a fresh start runs the full sequence.
